// File: rtl/aes128_pkg.sv
// rtl/aes128_pkg.sv - shared widths, default core latency and block type for the AES-128 decrypt feeder
package aes128_pkg;
    localparam int BLK_W            = 128;
    localparam int BYTE_W           = 8;
    localparam int BYTES_PER_BLK    = 16;
    localparam int DEFAULT_PIPE_LAT = 10;

    typedef logic [BLK_W-1:0] aes_block_t;
endpackage

// File: rtl/aes128_sync_fifo.sv
// rtl/aes128_sync_fifo.sv - synchronous flop FIFO with registered storage, full/empty flags, zero data when empty
module aes128_sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr, do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_rd   = rd_en && !empty;
    // A pop frees the head slot this cycle, so a write into a full FIFO may ride along with it.
    assign do_wr   = wr_en && (!full || rd_en);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge CLK) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end
endmodule

// File: rtl/aes128_dec_feeder.sv
// rtl/aes128_dec_feeder.sv - byte-to-block feeder, latency tracker and credit-guarded output FIFO for the AES-128 decrypt core
// Optional: define AES128_FEED_CNT_EN to enable the popped-block counter on blk_count.
module aes128_dec_feeder
    import aes128_pkg::*;
#(
    parameter int PIPE_LAT  = DEFAULT_PIPE_LAT,
    parameter int OUT_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             key_load,
    input  logic [BLK_W-1:0] key_in,
    input  logic             in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic             in_ready,
    output logic             dec_enable,
    output logic [BLK_W-1:0] dec_data,
    output logic [BLK_W-1:0] dec_key,
    input  logic [BLK_W-1:0] dec_result,
    output logic             out_valid,
    output logic [BLK_W-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic [31:0]      blk_count
);
    localparam int CW  = $clog2(OUT_DEPTH + 1);
    localparam int BCW = $clog2(BYTES_PER_BLK);
    localparam int PW  = BLK_W - BYTE_W;

    aes_block_t        key_q;
    logic              key_valid_q;
    logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
    logic [PW-1:0]     blk_q;
    logic              dec_enable_q;
    aes_block_t        dec_data_q;
    logic [CW-1:0]     credits_q, credits_d;
    logic [PIPE_LAT-1:0] vld_q;

    logic accept, last_byte, issue, pop, key_we;
    logic fifo_full, fifo_empty;

    assign last_byte = (byte_cnt_q == BCW'(BYTES_PER_BLK - 1));
    assign busy      = (byte_cnt_q != '0) || (credits_q != CW'(OUT_DEPTH));
    // The core key schedule is combinational, so the key may only change with nothing partial or in flight.
    assign key_we    = key_load && !busy;
    assign in_ready  = key_valid_q && !key_load && !(last_byte && (credits_q == '0));
    assign accept    = in_valid && in_ready;
    assign issue     = accept && last_byte;
    assign pop       = out_valid && out_ready;

    always_comb begin
        credits_d  = credits_q;
        byte_cnt_d = byte_cnt_q;
        if (issue && !pop) begin
            credits_d = credits_q - CW'(1);
        end else if (pop && !issue) begin
            credits_d = credits_q + CW'(1);
        end
        if (accept) begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            key_q        <= '0;
            key_valid_q  <= 1'b0;
            byte_cnt_q   <= '0;
            blk_q        <= '0;
            dec_enable_q <= 1'b0;
            dec_data_q   <= '0;
            credits_q    <= CW'(OUT_DEPTH);
            vld_q        <= '0;
        end else begin
            if (key_we) begin
                key_q       <= key_in;
                key_valid_q <= 1'b1;
            end
            if (accept) begin
                blk_q <= {blk_q[PW-BYTE_W-1:0], in_data};
            end
            if (issue) begin
                dec_data_q <= {blk_q, in_data};
            end
            byte_cnt_q   <= byte_cnt_d;
            credits_q    <= credits_d;
            dec_enable_q <= issue;
            vld_q        <= {vld_q[PIPE_LAT-2:0], dec_enable_q};
        end
    end

    aes128_sync_fifo #(
        .WIDTH(BLK_W),
        .DEPTH(OUT_DEPTH)
    ) u_out_fifo (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .wr_en  (vld_q[PIPE_LAT-1]),
        .wr_data(dec_result),
        .rd_en  (out_ready),
        .rd_data(out_data),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign out_valid  = !fifo_empty;
    assign dec_enable = dec_enable_q;
    assign dec_data   = dec_data_q;
    assign dec_key    = key_q;

    // Credits reserve a slot for every issued block, so a core result never meets a full FIFO without a pop.
    assert property (@(posedge CLK) disable iff (!RST_N) !(vld_q[PIPE_LAT-1] && fifo_full && !out_ready));

`ifdef AES128_FEED_CNT_EN
    logic [31:0] blk_cnt_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            blk_cnt_q <= '0;
        end else if (pop) begin
            blk_cnt_q <= blk_cnt_q + 32'd1;
        end
    end

    assign blk_count = blk_cnt_q;
`else
    assign blk_count = '0;
`endif
endmodule

// File: tb/tb_aes128_dec_feeder.sv
// tb/tb_aes128_dec_feeder.sv - scoreboard bench for aes128_dec_feeder with a behavioural core and transaction-level model
module tb_aes128_dec_feeder;
    localparam int PIPE_LAT  = 10;
    localparam int OUT_DEPTH = 4;
`ifdef AES128_FEED_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         key_load;
    logic [127:0] key_in;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic         dec_enable;
    logic [127:0] dec_data;
    logic [127:0] dec_key;
    logic [127:0] dec_result;
    logic         out_valid;
    logic [127:0] out_data;
    logic         out_ready;
    logic         busy;
    logic [31:0]  blk_count;

    aes128_dec_feeder #(.PIPE_LAT(PIPE_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .key_load(key_load), .key_in(key_in),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .dec_enable(dec_enable), .dec_data(dec_data), .dec_key(dec_key),
        .dec_result(dec_result), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy), .blk_count(blk_count)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge CLK) cyc++;

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stand-in for the decrypt core: the FIPS-197 pair decrypts correctly, anything else maps to a keyed scramble.
    function automatic logic [127:0] core_f(input logic [127:0] ct, input logic [127:0] k);
        if (ct == FIPS_CT && k == FIPS_KEY) return FIPS_PT;
        return ct ^ {k[63:0], k[127:64]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
    endfunction

    logic [127:0] pipe_q [PIPE_LAT];
    always @(posedge CLK) begin
        pipe_q[0] <= dec_enable ? core_f(dec_data, dec_key) : {$urandom, $urandom, $urandom, $urandom};
        for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign dec_result = pipe_q[PIPE_LAT-1];

    // Transaction-level model: bytes collected per block, outstanding results queued with their earliest visible cycle.
    bit           m_kv;
    logic [127:0] m_key;
    int           m_n;
    logic [127:0] m_blk;
    logic [127:0] sbq [$];
    int           rdyq [$];
    bit           m_den;
    logic [127:0] m_den_blk;
    logic [31:0]  m_pops;
    int           act_issued = 0;
    int           acc15_cyc = 0;
    int           ov_rise_cyc = 0;
    bit           ov_prev = 1'b0;
    logic [127:0] last_pop = '0;

    always @(negedge CLK) begin : monitor
        bit m_busy, exp_ir, exp_ov;
        if (dec_enable === 1'b1) act_issued++;
        if (out_valid === 1'b1 && !ov_prev) ov_rise_cyc = cyc;
        ov_prev = (out_valid === 1'b1);
        if (RST_N !== 1'b1) begin
            m_kv = 1'b0; m_key = '0; m_n = 0; m_blk = '0; m_den = 1'b0; m_den_blk = '0; m_pops = '0;
            sbq.delete();
            rdyq.delete();
        end else begin
            m_busy = (m_n != 0) || (sbq.size() != 0);
            exp_ir = m_kv && !key_load && !(m_n == 15 && sbq.size() == OUT_DEPTH);
            exp_ov = (sbq.size() != 0) && (rdyq[0] <= cyc);
            chk1("in_ready", in_ready, exp_ir);
            chk1("out_valid", out_valid, exp_ov);
            chk1("busy", busy, m_busy);
            chk1("dec_enable", dec_enable, m_den);
            if (m_den) chk128("dec_data", dec_data, m_den_blk);
            chk128("dec_key", dec_key, m_key);
            chk128("blk_count", 128'(blk_count), CNT_EN ? 128'(m_pops) : 128'(0));
            m_den = 1'b0;
            if (exp_ov && out_ready) begin
                chk128("out_data", out_data, sbq[0]);
                last_pop = out_data;
                void'(sbq.pop_front());
                void'(rdyq.pop_front());
                m_pops = m_pops + 32'd1;
            end
            if (in_valid && exp_ir) begin
                m_blk = {m_blk[119:0], in_data};
                if (m_n == 15) begin
                    sbq.push_back(core_f(m_blk, m_key));
                    rdyq.push_back(cyc + PIPE_LAT + 2);
                    m_den = 1'b1;
                    m_den_blk = m_blk;
                    acc15_cyc = cyc;
                    m_n = 0;
                end else begin
                    m_n++;
                end
            end
            if (key_load && !m_busy) begin
                m_key = key_in;
                m_kv = 1'b1;
            end
        end
    end

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge CLK);
        while (in_ready !== 1'b1 && w < 1000) begin
            @(negedge CLK);
            w++;
        end
        if (in_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_byte_timeout: in_ready stuck at %b, required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [127:0] b, input int nb, input int gap);
        for (int i = 0; i < nb; i++) begin
            send_byte(b[127-8*i -: 8]);
            if (gap > 0) repeat ($urandom_range(0, gap)) step();
        end
    endtask

    task automatic load_key(input logic [127:0] k);
        key_load = 1'b1;
        key_in   = k;
        step();
        key_load = 1'b0;
    endtask

    task automatic wait_drain;
        int w = 0;
        out_ready = 1'b1;
        while (sbq.size() != 0 && w < 600) begin
            step();
            w++;
        end
        repeat (2) step();
        chk1("drain_done", sbq.size() == 0, 1'b1);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    bit rnd_done = 1'b0;
    int base_iss;
    logic [127:0] key_b, blk_r;

    initial begin
        RST_N = 1'b0; key_load = 1'b0; key_in = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) step();
        RST_N = 1'b1;
        @(negedge CLK);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_dec_enable", dec_enable, 1'b0);
        chk128("rst_dec_data", dec_data, '0);
        chk128("rst_dec_key", dec_key, '0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk128("rst_out_data", out_data, '0);
        chk1("rst_busy", busy, 1'b0);
        chk128("rst_blk_count", 128'(blk_count), '0);
        step();

        load_key(FIPS_KEY);
        out_ready = 1'b1;
        send_bytes(FIPS_CT, 16, 0);
        wait_drain();
        chk128("fips_plaintext", last_pop, FIPS_PT);
        chk128("fips_latency", 128'(ov_rise_cyc - acc15_cyc), 128'(12));

        fork
            begin
                for (int k = 0; k < 12; k++) send_bytes(rnd128(), 16, 2);
                rnd_done = 1'b1;
            end
            begin
                int ph = 0;
                while (!rnd_done) begin
                    step();
                    if (ph == 0) ph = $urandom_range(1, 70);
                    ph--;
                    out_ready = (ph < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
                end
            end
        join
        wait_drain();
        @(negedge CLK);
        chk1("random_credits_home", busy, 1'b0);
        step();

        out_ready = 1'b0;
        base_iss = act_issued;
        fork
            begin
                for (int k = 0; k < 6; k++) send_bytes(rnd128(), 16, 0);
            end
            begin
                repeat (150) step();
                @(negedge CLK);
                chk128("bp_issued_4", 128'(act_issued - base_iss), 128'(4));
                chk1("bp_stall_in_ready", in_ready, 1'b0);
                step();
                out_ready = 1'b1;
                step();
                out_ready = 1'b0;
                repeat (3) step();
                @(negedge CLK);
                chk128("bp_issued_5", 128'(act_issued - base_iss), 128'(5));
                step();
                out_ready = 1'b1;
            end
        join
        wait_drain();

        out_ready = 1'b1;
        send_bytes(rnd128(), 16, 0);
        key_b = rnd128();
        load_key(key_b);
        @(negedge CLK);
        chk128("key_ignored_busy", dec_key, FIPS_KEY);
        step();
        wait_drain();
        load_key(key_b);
        @(negedge CLK);
        chk128("key_loaded_idle", dec_key, key_b);
        step();
        send_bytes(rnd128(), 16, 1);
        wait_drain();

        out_ready = 1'b0;
        send_bytes(rnd128(), 16, 0);
        send_bytes(rnd128(), 16, 0);
        send_bytes(rnd128(), 7, 0);
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        out_ready = 1'b1;
        repeat (25) step();
        @(negedge CLK);
        chk1("post_rst_busy", busy, 1'b0);
        chk1("post_rst_out_valid", out_valid, 1'b0);
        step();
        load_key(key_b);
        blk_r = rnd128();
        send_bytes(blk_r, 16, 0);
        wait_drain();
        chk128("post_rst_block", last_pop, core_f(blk_r, key_b));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
